stage_select: RTL



---
 rtl/stage_select.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/stage_select.sv
// Switch-driven stage selector: synchronises, debounces and validates a 10-bit thermometer
// switch code and commits stage 0..9. Optional macro STAGE_SELECT_BUBBLE_FIX_EN corrects bubbled codes.
module stage_select #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [9:0]  sw,
  input  logic        hold,
  output logic [31:0] stage,
  output logic        stage_change,
  output logic        code_error
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [9:0] CODE_RST = 10'b0000000001;

  typedef enum logic [1:0] {
    ST_STABLE = 2'd0,
    ST_SETTLE = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [9:0]    r_s1, r_s2;
  logic [9:0]    r_ref_code, w_ref_nxt;
  logic [9:0]    r_cand, w_cand_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]    r_stage, w_stage_nxt;
  logic          r_change, w_change_nxt;
  logic          r_error, w_error_nxt;
  logic [4:0]    w_dec;

  // Returns {legal, stage}; stage is only meaningful when legal is set.
  function automatic logic [4:0] f_decode(input logic [9:0] code);
    logic [3:0] v_acc;
    logic       v_ok;
    v_acc = 4'd0;
    v_ok  = 1'b0;
`ifdef STAGE_SELECT_BUBBLE_FIX_EN
    for (int i = 0; i < 10; i++) begin
      if (code[i]) begin
        v_acc = 4'(i);
        v_ok  = 1'b1;
      end
    end
`else
    for (int i = 0; i < 10; i++) begin
      v_acc = v_acc + {3'd0, code[i]};
    end
    v_ok  = (code != 10'd0) && ((code & (code + 10'd1)) == 10'd0);
    v_acc = v_acc - 4'd1;
`endif
    return {v_ok, v_acc};
  endfunction

  assign w_dec        = f_decode(r_cand);
  assign stage        = {28'd0, r_stage};
  assign stage_change = r_change;
  assign code_error   = r_error;

  // Synchroniser and all state registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_s1       <= CODE_RST;
      r_s2       <= CODE_RST;
      r_state    <= ST_STABLE;
      r_ref_code <= CODE_RST;
      r_cand     <= CODE_RST;
      r_cnt      <= '0;
      r_stage    <= 4'd0;
      r_change   <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_s1       <= sw;
      r_s2       <= r_s1;
      r_state    <= w_state_nxt;
      r_ref_code <= w_ref_nxt;
      r_cand     <= w_cand_nxt;
      r_cnt      <= w_cnt_nxt;
      r_stage    <= w_stage_nxt;
      r_change   <= w_change_nxt;
      r_error    <= w_error_nxt;
    end
  end

  // Debounce FSM: any change of the synchronised sample restarts settling.
  always_comb begin
    w_state_nxt  = r_state;
    w_ref_nxt    = r_ref_code;
    w_cand_nxt   = r_cand;
    w_cnt_nxt    = r_cnt;
    w_stage_nxt  = r_stage;
    w_change_nxt = 1'b0;
    w_error_nxt  = r_error;
    case (r_state)
      ST_STABLE: begin
        if (r_s2 != r_ref_code) begin
          w_state_nxt = ST_SETTLE;
          w_cand_nxt  = r_s2;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = ST_STABLE;
        end
      end
      ST_SETTLE: begin
        if (r_s2 != r_cand) begin
          w_cand_nxt = r_s2;
          w_cnt_nxt  = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_COMMIT;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      ST_COMMIT: begin
        if (r_s2 != r_cand) begin
          w_state_nxt = ST_SETTLE;
          w_cand_nxt  = r_s2;
          w_cnt_nxt   = '0;
        end else if (hold) begin
          w_state_nxt = ST_COMMIT;
        end else begin
          w_ref_nxt   = r_cand;
          w_state_nxt = ST_STABLE;
          if (w_dec[4]) begin
            w_stage_nxt  = w_dec[3:0];
            w_error_nxt  = 1'b0;
            w_change_nxt = (w_dec[3:0] != r_stage);
          end else begin
            w_error_nxt = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_STABLE;
      end
    endcase
  end

endmodule
